uart_rx_c5gx: RTL and testbench
===============================

// Module: uart_rx_c5gx
// PURPOSE
//  8N1 UART receiver: the input side of the board serial link whose output side is driven on o_tx.
//  Deserialises i_rx into bytes and presents each byte through a one-entry valid/ready register.
//  The core's MMIO UART block consumes these bytes.
//  Reports framing errors and overruns as single-cycle pulses.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency in Hz
//  BAUD     115_200     line rate; DIV = CLK_HZ/BAUD (integer, truncated) = 434 at defaults
// PORTS
//  i_clk_50mhz  in   1  system clock; all logic is in this single domain
//  i_reset_n    in   1  asynchronous, active-low reset
//  i_rx         in   1  serial line, idle high, asynchronous to the clock
//  o_data       out  8  received byte, LSB first on the line; stable while o_valid=1
//  o_valid      out  1  o_data holds an unconsumed byte
//  i_ready      in   1  consumer accepts; transfer occurs on a clock edge with o_valid & i_ready
//  o_frame_err  out  1  one-cycle pulse: stop bit sampled low
//  o_overrun    out  1  one-cycle pulse: a byte completed while the register was still full
// BEHAVIOUR
//  Reset values: o_data=8'h00, o_valid=0, o_frame_err=0, o_overrun=0.
//  Reset also sets state=IDLE, all counters=0, and both synchroniser flops=1.
//  Reset asserted mid-frame aborts the frame; nothing partial is ever output.
//  Synchroniser: i_rx passes through 2 flops to give rx_s; edge detect uses rx_s and its delayed copy.
//  Bit timer: counter 0..DIV-1. HALF = DIV/2 = 217.
//  State IDLE:
//   - falling edge on rx_s -> START, timer cleared.
//  State START:
//   - at timer==HALF-1, if rx_s==0 -> DATA with timer=0 and bit index=0.
//   - if rx_s==1 at that point, it is a glitch -> IDLE; nothing is output.
//  State DATA:
//   - sample rx_s at each timer==DIV-1, i.e. at mid-bit.
//   - shift the sample into shreg[7] with a right shift, so the first bit received ends up in bit 0.
//   - after the 8th sample -> STOP.
//  State STOP:
//   - sample at timer==DIV-1.
//   - rx_s==1 -> byte complete -> IDLE.
//   - rx_s==0 -> o_frame_err pulses for 1 cycle, the byte is discarded -> WAIT_IDLE.
//  State WAIT_IDLE:
//   - stay until rx_s==1 (this covers break conditions), then -> IDLE.
//   - no new start is detected while in this state.
//  Output register, on byte complete:
//   - empty, or emptying this cycle (o_valid & i_ready): load o_data; o_valid=1 from the next cycle.
//   - full and not being consumed: keep the old o_data, drop the new byte, pulse o_overrun for 1 cycle.
//  On o_valid & i_ready with no byte completing, o_valid clears the next cycle.
//  Latency: o_valid rises 1 cycle after the stop-bit mid sample.
//   - that sample falls ~9.5 bit times after the start edge, plus 2 cycles of synchroniser delay.
//  Back-to-back frames with no idle gap are supported.
//   - IDLE is re-entered at stop-bit mid, before the next start edge arrives.
//  o_frame_err and o_overrun never assert in the same cycle.
// STRUCTURE
//  Shared package uart_pkg, also used by the matching transmitter:
//   - state encoding IDLE/START/DATA/STOP/WAIT_IDLE.
//   - default CLK_HZ and BAUD.
//   - divisor function div_f(clk_hz, baud).
//  Sub-module sync_2ff: generic 2-flop synchroniser with a reset-value parameter, set to 1 here.
//  Remainder in one module: FSM, bit timer, bit index, shift register, output register.
// TESTING
//  All serial stimulus is driven at DIV=434 cycles per bit, with i_ready=1 unless stated.
//  1. Send 0x55, then 0xA3 with no gap -> o_valid pulses twice, o_data = 0x55 then 0xA3, no error pulses.
//  2. i_rx low for 100 cycles, then high -> no o_valid, no o_frame_err; the next frame 0x3C is received correctly.
//  3. Send 0x81 with the stop bit driven low, then hold the line low for 5 bit times before releasing it:
//     - o_frame_err pulses exactly once, no o_valid.
//     - a following 0x42 is received correctly.
//  4. i_ready=0, then send 0x11 and 0x22:
//     - o_valid=1 with o_data=0x11 throughout.
//     - o_overrun pulses once at the end of 0x22.
//     - raising i_ready for 1 cycle clears o_valid.
//  5. Assert i_reset_n=0 for 3 cycles in the middle of the 4th data bit of a frame:
//     - all outputs read 0 during reset.
//     - the aborted frame produces no output.
//     - the next full frame 0xF0 is received correctly.
//  6. Timing check: o_valid rises within [9.5*434+2, 9.5*434+4] cycles of the start falling edge.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART definitions (state encoding, default rates, divisor)
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    localparam int c_DEFAULT_CLK_HZ = 50_000_000;
    localparam int c_DEFAULT_BAUD   = 115_200;

    // Cycles per bit, truncated toward zero.
    function automatic int div_f(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : generic two-flop synchroniser with configurable reset value
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= {WIDTH{RST_VAL}};
            sync_q <= {WIDTH{RST_VAL}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_c5gx.sv
// ============================================================================
// uart_rx_c5gx : 8N1 UART receiver with one-entry valid/ready output register
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_c5gx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = c_DEFAULT_CLK_HZ,
    parameter int BAUD   = c_DEFAULT_BAUD
) (
    input  logic       i_clk_50mhz,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int DIV  = div_f(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int TW   = $clog2(DIV);

    localparam logic [TW-1:0] c_DIV_M1  = TW'(DIV - 1);
    localparam logic [TW-1:0] c_HALF_M1 = TW'(HALF - 1);

    logic          rx_s;
    logic          rx_prev_q;
    logic [2:0]    state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [2:0]    bit_idx_q,   bit_idx_d;
    logic [7:0]    shreg_q,     shreg_d;
    logic [7:0]    data_q,      data_d;
    logic          valid_q,     valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q,   overrun_d;
    logic          byte_done;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i  (i_clk_50mhz),
        .rst_ni (i_reset_n),
        .d_i    (i_rx),
        .q_o    (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;

        case (state_q)
            c_IDLE: begin
                timer_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = c_START;
                end
            end
            c_START: begin
                if (timer_q == c_HALF_M1) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? c_IDLE : c_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            c_DATA: begin
                if (timer_q == c_DIV_M1) begin
                    timer_d   = '0;
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = c_STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            c_STOP: begin
                if (timer_q == c_DIV_M1) begin
                    timer_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = c_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = c_WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            c_WAIT_IDLE: begin
                timer_d = '0;
                if (rx_s) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
                timer_d = '0;
            end
        endcase

        // A byte may land in the same cycle the consumer drains the register.
        if (byte_done) begin
            if (!valid_q || i_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_prev_q   <= 1'b1;
            state_q     <= c_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_prev_q   <= rx_s;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_c5gx.sv
// ============================================================================
// tb_uart_rx_c5gx : self-checking bench for uart_rx_c5gx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_c5gx;

    localparam int DIV = 434;

    logic       clk;
    logic       i_reset_n;
    logic       i_rx;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    uart_rx_c5gx dut (
        .i_clk_50mhz (clk),
        .i_reset_n   (i_reset_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: bytes that must be delivered, and expected error pulse counts.
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;

    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         rise_cnt  = 0;
    int         rise_cyc  = 0;
    int         got_cnt   = 0;
    logic [7:0] last_got  = 8'h00;
    logic [7:0] got[$];
    int         start_cyc = 0;

    bit   rand_mode  = 1'b0;
    logic ready_fixed = 1'b1;

    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        i_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        if (!i_reset_n) begin
            prev_valid <= 1'b0;
            prev_hs    <= 1'b0;
        end else begin
            if (o_frame_err) ferr_cnt++;
            if (o_overrun)   ovr_cnt++;
            if (o_frame_err && o_overrun) check("err_exclusive", 32'd1, 32'd0);
            if (prev_valid && !prev_hs) begin
                check("valid_held", {31'd0, o_valid}, 32'd1);
                check("data_stable", {24'd0, o_data}, {24'd0, prev_data});
            end
            if (o_valid && !prev_valid) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, o_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'd0, o_data}, {24'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                got.push_back(o_data);
                last_got = o_data;
                got_cnt++;
            end
            prev_valid <= o_valid;
            prev_hs    <= o_valid & i_ready;
            prev_data  <= o_data;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; leaves the line at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit expect_drop);
        start_cyc = cyc;
        i_rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            wait_cycles(DIV);
        end
        i_rx = stop_ok;
        if (!stop_ok)         exp_ferr++;
        else if (expect_drop) exp_ovr++;
        else                  exp_q.push_back(b);
        wait_cycles(DIV);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr"},  ovr_cnt,  exp_ovr);
        check({tag, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        i_rx      = 1'b1;
        i_reset_n = 1'b0;
        i_ready   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data",  {24'd0, o_data}, 32'h0);
        check("rst_valid", {31'd0, o_valid}, 32'h0);
        check("rst_ferr",  {31'd0, o_frame_err}, 32'h0);
        check("rst_ovr",   {31'd0, o_overrun}, 32'h0);
        i_reset_n = 1'b1;
        wait_cycles(2 * DIV);

        // Back-to-back frames
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, 1'b0);
        wait_cycles(DIV);
        check("t1_count", got.size(), 2);
        if (got.size() == 2) begin
            check("t1_first",  {24'd0, got[0]}, 32'h55);
            check("t1_second", {24'd0, got[1]}, 32'hA3);
        end
        check("t1_ferr_lit", ferr_cnt, 0);
        check("t1_ovr_lit",  ovr_cnt, 0);
        check_errs("t1");

        // Start-bit glitch
        r0 = rise_cnt;
        i_rx = 1'b0;
        wait_cycles(100);
        i_rx = 1'b1;
        wait_cycles(3 * DIV);
        check("t2_no_valid", rise_cnt, r0);
        check("t2_no_ferr",  ferr_cnt, 0);
        send_byte(8'h3C, 1'b1, 1'b0);
        wait_cycles(DIV);
        check("t2_byte", {24'd0, last_got}, 32'h3C);
        check_errs("t2");

        // Framing error followed by a break
        r0 = rise_cnt;
        send_byte(8'h81, 1'b0, 1'b0);
        wait_cycles(5 * DIV);
        i_rx = 1'b1;
        wait_cycles(2 * DIV);
        check("t3_ferr_lit", ferr_cnt, 1);
        check("t3_no_valid", rise_cnt, r0);
        send_byte(8'h42, 1'b1, 1'b0);
        wait_cycles(DIV);
        check("t3_byte", {24'd0, last_got}, 32'h42);
        check_errs("t3");

        // Overrun with consumer stalled
        ready_fixed = 1'b0;
        wait_cycles(DIV);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b1);
        wait_cycles(DIV);
        check("t4_valid",   {31'd0, o_valid}, 32'h1);
        check("t4_data",    {24'd0, o_data}, 32'h11);
        check("t4_ovr_lit", ovr_cnt, 1);
        ready_fixed = 1'b1;
        wait_cycles(1);
        ready_fixed = 1'b0;
        wait_cycles(3);
        check("t4_cleared", {31'd0, o_valid}, 32'h0);
        check("t4_last",    {24'd0, last_got}, 32'h11);
        ready_fixed = 1'b1;
        check_errs("t4");

        // Reset in the middle of the 4th data bit
        r0 = rise_cnt;
        i_rx = 1'b0;
        wait_cycles(4 * DIV + DIV / 2);
        i_reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t5_rst_data",  {24'd0, o_data}, 32'h0);
            check("t5_rst_valid", {31'd0, o_valid}, 32'h0);
            check("t5_rst_ferr",  {31'd0, o_frame_err}, 32'h0);
            check("t5_rst_ovr",   {31'd0, o_overrun}, 32'h0);
        end
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        i_rx = 1'b1;
        wait_cycles(12 * DIV);
        check("t5_no_valid", rise_cnt, r0);
        send_byte(8'hF0, 1'b1, 1'b0);
        wait_cycles(DIV);
        check("t5_byte", {24'd0, last_got}, 32'hF0);
        check_errs("t5");

        // Start edge to o_valid latency of the 0xF0 frame
        total++;
        if ((rise_cyc - start_cyc) < 4125 || (rise_cyc - start_cyc) > 4127) begin
            bad++;
            $display("FAIL latency: got %0d expected 4125..4127", rise_cyc - start_cyc);
        end

        // Randomised bytes, gaps and consumer back-pressure
        rand_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send_byte(8'($urandom()), 1'b1, 1'b0);
            i_rx = 1'b1;
            wait_cycles($urandom_range(0, DIV));
        end
        wait_cycles(2 * DIV);
        rand_mode = 1'b0;
        wait_cycles(4);
        check_errs("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
